// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//
// Single-issue instruction sequencer wrapped around an external
// combinational 8-bit ALU. It accepts one instruction, reads operands from
// a small register file and drives the ALU for instr_rep+1 chained
// iterations, feeding each result back into operand A. It then writes the
// final result to R[rd] and presents {result, flags} as a response that is
// held until the consumer accepts it.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   instr_valid/ready     instruction handshake (ready only in IDLE)
//   instr_op/rd/rs1/rs2   opcode, destination and source registers
//   instr_a_zero          force operand A to zero
//   instr_imm_sel/imm     use the immediate as operand B
//   instr_rep             extra iterations (executes instr_rep+1 times)
//   alu_a/alu_b/alu_opcode  registered ALU inputs
//   alu_result, alu_*     combinational ALU result and flags
//   rsp_valid/ready       response handshake
//   rsp_result/rsp_flags  final result and flags {Z,C,N,O}
//   dbg_addr/dbg_data     combinational register file read port
// ---------------------------------------------------------------------------
module alu_sequencer #(
    parameter int REG_COUNT = 4,
    parameter int MAX_REP_W = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         instr_valid,
    output logic                         instr_ready,
    input  logic [2:0]                   instr_op,
    input  logic [$clog2(REG_COUNT)-1:0] instr_rd,
    input  logic [$clog2(REG_COUNT)-1:0] instr_rs1,
    input  logic [$clog2(REG_COUNT)-1:0] instr_rs2,
    input  logic                         instr_a_zero,
    input  logic                         instr_imm_sel,
    input  logic [7:0]                   instr_imm,
    input  logic [MAX_REP_W-1:0]         instr_rep,
    output logic [7:0]                   alu_a,
    output logic [7:0]                   alu_b,
    output logic [2:0]                   alu_opcode,
    input  logic [7:0]                   alu_result,
    input  logic                         alu_zero,
    input  logic                         alu_carry,
    input  logic                         alu_negative,
    input  logic                         alu_overflow,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [7:0]                   rsp_result,
    output logic [3:0]                   rsp_flags,
    input  logic [$clog2(REG_COUNT)-1:0] dbg_addr,
    output logic [7:0]                   dbg_data
);

    localparam int AW = $clog2(REG_COUNT);

    // ISSUE is the settling cycle after accept: the freshly latched operands
    // reach the ALU before the first sampled iteration, giving the two-cycle
    // minimum accept-to-response latency.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        EXEC  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e                         state_q;
    logic [REG_COUNT-1:0][7:0]      regs_q;
    logic [7:0]                     alu_a_q;
    logic [7:0]                     alu_b_q;
    logic [2:0]                     alu_op_q;
    logic [MAX_REP_W-1:0]           rep_cnt_q;
    logic [AW-1:0]                  rd_q;
    logic [7:0]                     rsp_result_q;
    logic [3:0]                     rsp_flags_q;

    logic [7:0]                     op_a_d;
    logic [7:0]                     op_b_d;

    always_comb begin
        op_a_d = instr_a_zero  ? 8'd0      : regs_q[instr_rs1];
        op_b_d = instr_imm_sel ? instr_imm : regs_q[instr_rs2];
    end

    // Gated by rst_n so the sequencer never advertises readiness in reset.
    assign instr_ready = rst_n && (state_q == IDLE);
    assign rsp_valid   = (state_q == RESP);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_opcode  = alu_op_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_flags   = rsp_flags_q;
    assign dbg_data    = regs_q[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            regs_q       <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rep_cnt_q    <= '0;
            rd_q         <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (instr_valid) begin
                        alu_a_q   <= op_a_d;
                        alu_b_q   <= op_b_d;
                        alu_op_q  <= instr_op;
                        rep_cnt_q <= instr_rep;
                        rd_q      <= instr_rd;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= EXEC;
                end
                EXEC: begin
                    if (rep_cnt_q != '0) begin
                        // Chain: result becomes next operand A, B/op held.
                        alu_a_q   <= alu_result;
                        rep_cnt_q <= rep_cnt_q - MAX_REP_W'(1);
                    end else begin
                        regs_q[rd_q] <= alu_result;
                        rsp_result_q <= alu_result;
                        rsp_flags_q  <= {alu_zero, alu_carry, alu_negative, alu_overflow};
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_op;
    logic [1:0] instr_rd, instr_rs1, instr_rs2;
    logic       instr_a_zero, instr_imm_sel;
    logic [7:0] instr_imm;
    logic [3:0] instr_rep;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_opcode;
    logic [7:0] alu_result;
    logic       alu_zero, alu_carry, alu_negative, alu_overflow;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic [3:0] rsp_flags;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    int n_tot  = 0;
    int n_pass = 0;

    typedef struct {
        logic [7:0] res;
        logic [3:0] flg;
        logic [1:0] rd;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mreg[4];

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                           NOT_ = 3'd4, XOR_ = 3'd5, INC = 3'd6, DEC = 3'd7;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
        .instr_rs2(instr_rs2), .instr_a_zero(instr_a_zero),
        .instr_imm_sel(instr_imm_sel), .instr_imm(instr_imm),
        .instr_rep(instr_rep),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .alu_negative(alu_negative), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Reference 8-bit ALU: returns {Z,C,N,O,result}. Carry is the 9th bit of
    // the unsigned sum/difference (borrow for SUB/DEC).
    function automatic logic [11:0] alu_f(input logic [2:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        logic [8:0] s;
        logic       o;
        s = '0;
        o = 1'b0;
        case (op)
            ADD:  begin s = {1'b0, a} + {1'b0, b}; o = (a[7] == b[7]) && (s[7] != a[7]); end
            SUB:  begin s = {1'b0, a} - {1'b0, b}; o = (a[7] != b[7]) && (s[7] != a[7]); end
            AND_: s = {1'b0, a & b};
            OR_:  s = {1'b0, a | b};
            NOT_: s = {1'b0, ~a};
            XOR_: s = {1'b0, a ^ b};
            INC:  begin s = {1'b0, a} + 9'd1; o = (a == 8'h7f); end
            default: begin s = {1'b0, a} - 9'd1; o = (a == 8'h80); end
        endcase
        return {(s[7:0] == 8'd0), s[8], s[7], o, s[7:0]};
    endfunction

    // The external combinational ALU the sequencer drives.
    always_comb begin
        logic [11:0] r;
        r            = alu_f(alu_opcode, alu_a, alu_b);
        alu_result   = r[7:0];
        alu_zero     = r[11];
        alu_carry    = r[10];
        alu_negative = r[9];
        alu_overflow = r[8];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    endtask

    // Present an instruction, wait (bounded) for the accept edge, and push
    // the expected response computed from the model register file.
    task automatic send(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic az, input logic isel,
                        input logic [7:0] imm, input logic [3:0] rep);
        logic [7:0]  a, b;
        logic [11:0] r;
        bit          ok;
        exp_t        e;
        instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
        instr_a_zero = az; instr_imm_sel = isel; instr_imm = imm; instr_rep = rep;
        instr_valid = 1'b1;
        ok = 0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (instr_ready) ok = 1;
        end
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        chk("ready_low_after_accept", instr_ready, 1'b0);
        a = az ? 8'd0 : mreg[rs1];
        b = isel ? imm : mreg[rs2];
        r = '0;
        for (int i = 0; i <= int'(rep); i++) begin
            r = alu_f(op, a, b);
            a = r[7:0];
        end
        mreg[rd] = r[7:0];
        e.res = r[7:0]; e.flg = r[11:8]; e.rd = rd;
        sb.push_back(e);
    endtask

    // Wait for rsp_valid, checking latency, payload and the written register.
    task automatic wait_rsp(input int rep, input string tag);
        int   lat;
        bit   got;
        exp_t e;
        lat = 0; got = 0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) begin got = 1; lat = k; end
        end
        chk({tag, "_latency"}, lat, rep + 2);
        if (got && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_result"}, rsp_result, e.res);
            chk({tag, "_flags"}, rsp_flags, e.flg);
            dbg_addr = e.rd;
            #1 chk({tag, "_rd_written"}, dbg_data, e.res);
        end
    endtask

    task automatic ack();
        @(negedge clk) rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk("ready_after_ack", instr_ready, 1'b1);
        chk("valid_after_ack", rsp_valid, 1'b0);
    endtask

    initial begin
        logic [7:0] hold_res;
        logic [3:0] hold_flg;
        rst_n = 1'b0; instr_valid = 1'b0; rsp_ready = 1'b0; dbg_addr = '0;
        instr_op = '0; instr_rd = '0; instr_rs1 = '0; instr_rs2 = '0;
        instr_a_zero = 1'b0; instr_imm_sel = 1'b0; instr_imm = '0; instr_rep = '0;
        for (int i = 0; i < 4; i++) mreg[i] = 8'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_instr_ready", instr_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_alu_ops", {alu_a, alu_b, alu_opcode}, 19'd0);
        chk("rst_rsp", {rsp_result, rsp_flags}, 12'd0);
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1 chk("rst_dbg", dbg_data, 8'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_release", instr_ready, 1'b1);

        // Load and add
        send(ADD, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 8'd5, 4'd0); wait_rsp(0, "ld_r0"); ack();
        send(ADD, 2'd1, 2'd0, 2'd0, 1'b1, 1'b1, 8'd4, 4'd0); wait_rsp(0, "ld_r1"); ack();
        send(ADD, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0, 8'd0, 4'd0); wait_rsp(0, "add");
        chk("add_spec", {rsp_flags, rsp_result}, {4'b0000, 8'd9});
        ack();

        // Signed overflow
        send(ADD, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 8'd70, 4'd0); wait_rsp(0, "ld70"); ack();
        send(ADD, 2'd1, 2'd0, 2'd0, 1'b1, 1'b1, 8'd80, 4'd0); wait_rsp(0, "ld80"); ack();
        send(ADD, 2'd3, 2'd0, 2'd1, 1'b0, 1'b0, 8'd0, 4'd0); wait_rsp(0, "ovf");
        chk("ovf_spec", {rsp_flags, rsp_result}, {4'b0011, 8'h96});
        ack();

        // Repeat chaining, then carry-out at 255
        send(ADD, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 8'd250, 4'd0); wait_rsp(0, "ld250"); ack();
        send(INC, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 8'd0, 4'd7); wait_rsp(7, "inc_rep7");
        chk("inc_rep7_spec", {rsp_flags, rsp_result}, {4'b0000, 8'd2});
        ack();
        send(ADD, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 8'd255, 4'd0); wait_rsp(0, "ld255"); ack();
        send(INC, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 8'd0, 4'd0); wait_rsp(0, "inc255");
        chk("inc255_spec", {rsp_flags, rsp_result}, {4'b1100, 8'd0});
        ack();

        // Remaining opcodes with immediates and short repeats
        send(ADD, 2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 8'hA5, 4'd0); wait_rsp(0, "ldA5"); ack();
        for (int i = 0; i < 6; i++) begin
            logic [2:0] ops[6];
            ops = '{SUB, AND_, OR_, NOT_, XOR_, DEC};
            send(ops[i], 2'd3, 2'd0, 2'd0, 1'b0, 1'b1, 8'h3C, 4'(i % 3));
            wait_rsp(i % 3, "opmix");
            ack();
        end

        // Backpressure: response held, second instruction waits
        send(SUB, 2'd2, 2'd0, 2'd0, 1'b0, 1'b1, 8'h10, 4'd1); wait_rsp(1, "bp_first");
        hold_res = rsp_result; hold_flg = rsp_flags;
        instr_op = XOR_; instr_rd = 2'd1; instr_rs1 = 2'd2; instr_rs2 = 2'd0;
        instr_a_zero = 1'b0; instr_imm_sel = 1'b0; instr_rep = 4'd0;
        instr_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("bp_valid", rsp_valid, 1'b1);
            chk("bp_hold", {rsp_flags, rsp_result}, {hold_flg, hold_res});
            chk("bp_not_ready", instr_ready, 1'b0);
        end
        @(negedge clk) rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk("bp_ready_after_ack", instr_ready, 1'b1);
        send(XOR_, 2'd1, 2'd2, 2'd0, 1'b0, 1'b0, 8'd0, 4'd0); wait_rsp(0, "bp_second"); ack();

        // Reset mid-EXEC of a long instruction
        send(INC, 2'd1, 2'd1, 2'd0, 1'b0, 1'b0, 8'd0, 4'd15);
        repeat (4) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("midrst_valid", rsp_valid, 1'b0);
        chk("midrst_ready", instr_ready, 1'b0);
        sb.delete();
        for (int i = 0; i < 4; i++) mreg[i] = 8'd0;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 2'(i);
            #1 chk("midrst_regs", dbg_data, mreg[i]);
        end
        chk("midrst_ready_after", instr_ready, 1'b1);
        repeat (20) @(posedge clk);
        #1 chk("midrst_no_rsp", rsp_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
